// File: rtl/regfile_sb.sv
// Parametrised integer register file with dual read/write ports,
// write-to-read bypass, busy scoreboard and a sequential clear sweep.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int RFIDX_W  = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_rs1en,
  input  logic [RFIDX_W-1:0] i_rs1idx,
  output logic [XLEN-1:0]    o_rs1,
  output logic               o_rs1_busy,
  input  logic               i_rs2en,
  input  logic [RFIDX_W-1:0] i_rs2idx,
  output logic [XLEN-1:0]    o_rs2,
  output logic               o_rs2_busy,
  input  logic               i_w0en,
  input  logic [RFIDX_W-1:0] i_w0idx,
  input  logic [XLEN-1:0]    i_w0data,
  input  logic               i_w1en,
  input  logic [RFIDX_W-1:0] i_w1idx,
  input  logic [XLEN-1:0]    i_w1data,
  input  logic               i_iss_vld,
  input  logic [RFIDX_W-1:0] i_iss_rdidx,
  input  logic               i_clr_req,
  output logic               o_clr_busy,
  output logic               o_clr_done
);

  localparam int NREGS = 2 ** RFIDX_W;
  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nx;
  logic [RFIDX_W-1:0] ptr, ptr_nx;
  logic [XLEN-1:0] rf [NREGS];
  logic [NREGS-1:0] busy, busy_nx;
  logic sweep, w0, w1, iss;

  assign sweep = (state == SWEEP);

  // Writes and issue are dropped while the sweep owns the file
  assign w0  = i_w0en & ~sweep & ~(ZR & (i_w0idx == '0));
  assign w1  = i_w1en & ~sweep & ~(ZR & (i_w1idx == '0));
  assign iss = i_iss_vld & ~sweep & ~(ZR & (i_iss_rdidx == '0));

  function automatic logic hit(input logic [RFIDX_W-1:0] idx);
    return BP & ((w1 & (i_w1idx == idx)) | (w0 & (i_w0idx == idx)));
  endfunction

  function automatic logic [XLEN-1:0] rd_data(
    input logic               en,
    input logic [RFIDX_W-1:0] idx
  );
    logic [XLEN-1:0] d;
    d = rf[idx];
    if (!en || (ZR && idx == '0)) d = '0;
    else if (BP && w1 && i_w1idx == idx) d = i_w1data;
    else if (BP && w0 && i_w0idx == idx) d = i_w0data;
    return d;
  endfunction

  assign o_rs1 = rd_data(i_rs1en, i_rs1idx);
  assign o_rs2 = rd_data(i_rs2en, i_rs2idx);
  assign o_rs1_busy = i_rs1en & busy[i_rs1idx] & ~hit(i_rs1idx);
  assign o_rs2_busy = i_rs2en & busy[i_rs2idx] & ~hit(i_rs2idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (sweep) begin
      rf[ptr] <= '0;
    end else begin
      if (w0) rf[i_w0idx] <= i_w0data;
      if (w1) rf[i_w1idx] <= i_w1data;
    end
  end

  // Issue set is applied last so it wins over a same-cycle clear
  always_comb begin
    busy_nx = busy;
    if (sweep) begin
      busy_nx[ptr] = 1'b0;
    end else begin
      if (w0) busy_nx[i_w0idx] = 1'b0;
      if (w1) busy_nx[i_w1idx] = 1'b0;
      if (iss) busy_nx[i_iss_rdidx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      state <= IDLE;
      ptr   <= '0;
    end else begin
      busy  <= busy_nx;
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    o_clr_busy = 1'b0;
    o_clr_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_clr_req) begin
          state_nx = SWEEP;
          ptr_nx   = '0;
        end
      end
      SWEEP: begin
        o_clr_busy = 1'b1;
        ptr_nx     = ptr + 1'b1;
        if (ptr == {RFIDX_W{1'b1}}) state_nx = DONE;
      end
      DONE: begin
        o_clr_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: behavioural model with per-cycle compare
// plus directed checks on a default and a 64x16 instance.
module tb_regfile_sb;

  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rs1en, rs2en, w0en, w1en, iss_vld, clr_req;
  logic [4:0]  rs1idx, rs2idx, w0idx, w1idx, rd;
  logic [31:0] w0data, w1data, rs1, rs2;
  logic        rs1_busy, rs2_busy, clr_busy, clr_done;

  logic        b_rs1en, b_w0en, b_clr_req;
  logic [3:0]  b_rs1idx, b_w0idx;
  logic [63:0] b_w0data, b_rs1, b_rs2;
  logic        b_rs1_busy, b_rs2_busy, b_clr_busy, b_clr_done;

  int n_chk = 0;
  int n_err = 0;

  regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .i_rs1en(rs1en), .i_rs1idx(rs1idx),
    .o_rs1(rs1), .o_rs1_busy(rs1_busy),
    .i_rs2en(rs2en), .i_rs2idx(rs2idx),
    .o_rs2(rs2), .o_rs2_busy(rs2_busy),
    .i_w0en(w0en), .i_w0idx(w0idx), .i_w0data(w0data),
    .i_w1en(w1en), .i_w1idx(w1idx), .i_w1data(w1data),
    .i_iss_vld(iss_vld), .i_iss_rdidx(rd),
    .i_clr_req(clr_req),
    .o_clr_busy(clr_busy), .o_clr_done(clr_done)
  );

  regfile_sb #(.XLEN(64), .RFIDX_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_rs1en(b_rs1en), .i_rs1idx(b_rs1idx),
    .o_rs1(b_rs1), .o_rs1_busy(b_rs1_busy),
    .i_rs2en(1'b0), .i_rs2idx(4'd0),
    .o_rs2(b_rs2), .o_rs2_busy(b_rs2_busy),
    .i_w0en(b_w0en), .i_w0idx(b_w0idx), .i_w0data(b_w0data),
    .i_w1en(1'b0), .i_w1idx(4'd0), .i_w1data(64'd0),
    .i_iss_vld(1'b0), .i_iss_rdidx(4'd0),
    .i_clr_req(b_clr_req),
    .o_clr_busy(b_clr_busy), .o_clr_done(b_clr_done)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Model: register contents, pending bits, and sweep step
  // (-1 idle, 0..NR-1 sweeping that register, NR = done cycle)
  logic [31:0] mreg [NR];
  logic        mbusy [NR];
  int          mk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) begin
        mreg[i]  <= 32'd0;
        mbusy[i] <= 1'b0;
      end
      mk <= -1;
    end else if (mk >= 0 && mk < NR) begin
      mreg[mk]  <= 32'd0;
      mbusy[mk] <= 1'b0;
      mk        <= mk + 1;
    end else begin
      if (w0en && w0idx != 0) mreg[w0idx] <= w0data;
      if (w1en && w1idx != 0) mreg[w1idx] <= w1data;
      if (w0en) mbusy[w0idx] <= 1'b0;
      if (w1en) mbusy[w1idx] <= 1'b0;
      if (iss_vld && rd != 0) mbusy[rd] <= 1'b1;
      if (mk == NR) mk <= -1;
      else if (clr_req) mk <= 0;
    end
  end

  function automatic logic m_sweep();
    return (mk >= 0 && mk < NR);
  endfunction

  function automatic logic m_hit(input logic [4:0] idx);
    return !m_sweep() && ((w0en && w0idx == idx) || (w1en && w1idx == idx));
  endfunction

  function automatic logic [31:0] m_rd(input logic en, input logic [4:0] idx);
    if (!en || idx == 0) return 32'd0;
    if (!m_sweep() && w1en && w1idx == idx) return w1data;
    if (!m_sweep() && w0en && w0idx == idx) return w0data;
    return mreg[idx];
  endfunction

  always @(negedge clk) begin
    chk("cmp_rs1", rs1, m_rd(rs1en, rs1idx));
    chk("cmp_rs2", rs2, m_rd(rs2en, rs2idx));
    chk("cmp_rs1_busy", rs1_busy, rs1en && mbusy[rs1idx] && !m_hit(rs1idx));
    chk("cmp_rs2_busy", rs2_busy, rs2en && mbusy[rs2idx] && !m_hit(rs2idx));
    chk("cmp_clr_busy", clr_busy, m_sweep());
    chk("cmp_clr_done", clr_done, mk == NR);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_all();
    rs1en = 0; rs1idx = 0; rs2en = 0; rs2idx = 0;
    w0en = 0; w0idx = 0; w0data = 0;
    w1en = 0; w1idx = 0; w1data = 0;
    iss_vld = 0; rd = 0; clr_req = 0;
    b_rs1en = 0; b_rs1idx = 0; b_w0en = 0; b_w0idx = 0;
    b_w0data = 0; b_clr_req = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int nb, done_at;

  initial begin
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rs1en = 1; rs1idx = 5;
    smp();
    chk("rst_rs1", rs1, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    nxt();
    rst_n = 1'b1;

    // 1: write then read, and read disabled
    nxt(); rs1en = 0;
    w0en = 1; w0idx = 5; w0data = 32'hDEADBEEF;
    nxt(); w0en = 0; rs1en = 1; rs1idx = 5;
    smp(); chk("t1_rs1", rs1, 32'hDEADBEEF);
    #1 rs1en = 0;
    #1 chk("t1_rs1en0", rs1, 0);

    // 2: dual write same index, w1 wins, bypass
    nxt();
    w0en = 1; w0idx = 7; w0data = 32'h11;
    w1en = 1; w1idx = 7; w1data = 32'h22;
    rs1en = 1; rs1idx = 7;
    smp(); chk("t2_bypass", rs1, 32'h22);
    nxt(); w0en = 0; w1en = 0;
    smp(); chk("t2_stored", rs1, 32'h22);

    // 3: x0 hardwired
    nxt(); w0en = 1; w0idx = 0; w0data = 32'hFFFFFFFF;
    rs2en = 1; rs2idx = 0;
    smp(); chk("t3_x0_byp", rs2, 0);
    nxt(); w0en = 0; iss_vld = 1; rd = 0; rs1idx = 0;
    nxt(); iss_vld = 0;
    smp();
    chk("t3_x0_rd", rs1, 0);
    chk("t3_x0_busy", rs1_busy, 0);

    // 4: scoreboard
    nxt(); iss_vld = 1; rd = 9;
    nxt(); iss_vld = 0; rs2idx = 9;
    smp(); chk("t4_busy", rs2_busy, 1);
    nxt(); w1en = 1; w1idx = 9; w1data = 32'h99;
    smp(); chk("t4_busy_byp", rs2_busy, 0);
    chk("t4_rs2_byp", rs2, 32'h99);
    nxt(); w1en = 0;
    smp(); chk("t4_busy_clr", rs2_busy, 0);
    nxt(); iss_vld = 1; rd = 9;
    w0en = 1; w0idx = 9; w0data = 32'h55;
    nxt(); iss_vld = 0; w0en = 0;
    smp(); chk("t4_set_wins", rs2_busy, 1);
    chk("t4_rs2", rs2, 32'h55);

    // 5: fill, then sweep with writes held on
    for (int i = 1; i < NR; i++) begin
      nxt();
      w0en = 1; w0idx = 5'(i); w0data = 32'h1000_0000 + i;
      iss_vld = 1; rd = 5'(i);
    end
    nxt(); iss_vld = 0;
    w0idx = 3; w0data = 32'hABC; clr_req = 1;
    rs1idx = 31; rs2idx = 2;
    nxt(); clr_req = 0;
    w0idx = 4; w0data = 32'h77; iss_vld = 1; rd = 6;
    nb = 0; done_at = 0;
    for (int c = 1; c <= 40; c++) begin
      smp();
      if (clr_busy) nb++;
      if (clr_done && done_at == 0) done_at = c;
      nxt();
      if (c == 9) clr_req = 1;
      if (c == 10) clr_req = 0;
      if (c == 28) begin w0en = 0; iss_vld = 0; end
    end
    chk("t5_busy_cycles", nb, 32);
    chk("t5_done_cycle", done_at, 33);
    for (int i = 0; i < NR; i++) begin
      nxt(); rs1idx = 5'(i); rs2idx = 5'(NR - 1 - i);
      smp();
      chk("t5_rs1_zero", rs1, 0);
      chk("t5_rs1_busy0", rs1_busy, 0);
    end

    // 6: reset in the middle of a sweep
    nxt(); w0en = 1; w0idx = 31; w0data = 32'h31;
    iss_vld = 1; rd = 30;
    nxt(); w0en = 0; iss_vld = 0; clr_req = 1;
    nxt(); clr_req = 0;
    repeat (9) nxt();
    rst_n = 1'b0;
    rs1idx = 31; rs2idx = 30;
    smp();
    chk("t6_clr_busy", clr_busy, 0);
    chk("t6_x31", rs1, 0);
    chk("t6_busy30", rs2_busy, 0);
    nxt(); rst_n = 1'b1;
    nxt(); smp();
    chk("t6_idle", clr_busy, 0);
    chk("t6_x31_after", rs1, 0);

    // 64-bit, 16-entry instance
    nxt(); b_w0en = 1; b_w0idx = 5; b_w0data = 64'hDEADBEEF_CAFEF00D;
    nxt(); b_w0en = 0; b_rs1en = 1; b_rs1idx = 5;
    smp(); chk("b_rs1", b_rs1, 64'hDEADBEEF_CAFEF00D);
    nxt(); b_clr_req = 1;
    nxt(); b_clr_req = 0;
    nb = 0; done_at = 0;
    for (int c = 1; c <= 25; c++) begin
      smp();
      if (b_clr_busy) nb++;
      if (b_clr_done && done_at == 0) done_at = c;
      nxt();
    end
    chk("b_busy_cycles", nb, 16);
    chk("b_done_cycle", done_at, 17);
    smp(); chk("b_rs1_zero", b_rs1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
